// File: rtl/pri_enc_iter.sv
// Iterative priority encoder: emits the index of every active bit of a vector, one beat each.
// Latency: first beat one cycle after acceptance, then one beat per cycle while out_ready is high.
// Backpressure: beats hold stable while out_ready is low; in_ready is high only between vectors.

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module pri_enc_iter #(
    parameter int  IN        = 32,
    parameter bit  ACT       = `High,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int OUT       = $clog2(IN)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IN-1:0]  in_vec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT-1:0] out_idx,
    output logic           out_last,
    output logic           out_none
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IN-1:0]   pend_q, pend_d;
    logic [IN-1:0]   norm_vec;
    logic [IN-1:0]   sel_onehot;
    logic [OUT-1:0]  sel_idx;
    logic            pend_zero;
    logic            pend_single;

    assign norm_vec    = ACT ? in_vec : ~in_vec;
    assign pend_zero   = (pend_q == '0);
    // Clearing the lowest set bit leaves zero iff at most one bit was set.
    assign pend_single = ((pend_q & (pend_q - IN'(1))) == '0);

    // Later loop iterations override earlier ones, so the scan runs toward the winning end.
    always_comb begin
        sel_idx    = '0;
        sel_onehot = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < IN; i++) begin
                if (pend_q[i]) begin
                    sel_idx       = OUT'(i);
                    sel_onehot    = '0;
                    sel_onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = IN - 1; i >= 0; i--) begin
                if (pend_q[i]) begin
                    sel_idx       = OUT'(i);
                    sel_onehot    = '0;
                    sel_onehot[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SCAN);
        out_idx   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;

        if (state_q == SCAN) begin
            out_idx  = sel_idx;
            out_last = pend_single;
            out_none = pend_zero;
        end

        if (flush) begin
            state_d = IDLE;
            pend_d  = '0;
        end else if (state_q == IDLE) begin
            if (in_valid) begin
                pend_d  = norm_vec;
                state_d = SCAN;
            end
        end else if (out_ready) begin
            pend_d = pend_q & ~sel_onehot;
            if (pend_single) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_pri_enc_iter.sv
// Directed bench for pri_enc_iter over four parameter sets sharing clock, reset and flush.

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module tb_pri_enc_iter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       ivld = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] vin = 8'h00;
    int         sel = 0;

    logic       iv0, iv1, iv2, iv3;
    logic       ir0, ir1, ir2, ir3;
    logic       ov0, ov1, ov2, ov3;
    logic       ol0, ol1, ol2, ol3;
    logic       on0, on1, on2, on3;
    logic [2:0] oi0, oi1, oi2, oi3;

    logic       c_ir, c_ov, c_ol, c_on;
    logic [3:0] c_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign iv0 = ivld && (sel == 0);
    assign iv1 = ivld && (sel == 1);
    assign iv2 = ivld && (sel == 2);
    assign iv3 = ivld && (sel == 3);

    pri_enc_iter #(.IN(8), .ACT(`High), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_vec(vin),
        .out_valid(ov0), .out_ready(out_ready), .out_idx(oi0),
        .out_last(ol0), .out_none(on0));

    pri_enc_iter #(.IN(8), .ACT(`High), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_vec(vin),
        .out_valid(ov1), .out_ready(out_ready), .out_idx(oi1),
        .out_last(ol1), .out_none(on1));

    pri_enc_iter #(.IN(8), .ACT(`Low), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv2), .in_ready(ir2), .in_vec(vin),
        .out_valid(ov2), .out_ready(out_ready), .out_idx(oi2),
        .out_last(ol2), .out_none(on2));

    pri_enc_iter #(.IN(5), .ACT(`High), .MSB_FIRST(1'b0)) u3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv3), .in_ready(ir3), .in_vec(vin[4:0]),
        .out_valid(ov3), .out_ready(out_ready), .out_idx(oi3),
        .out_last(ol3), .out_none(on3));

    always_comb begin
        c_ir  = ir0; c_ov = ov0; c_ol = ol0; c_on = on0; c_idx = {1'b0, oi0};
        case (sel)
            1: begin c_ir = ir1; c_ov = ov1; c_ol = ol1; c_on = on1; c_idx = {1'b0, oi1}; end
            2: begin c_ir = ir2; c_ov = ov2; c_ol = ol2; c_on = on2; c_idx = {1'b0, oi2}; end
            3: begin c_ir = ir3; c_ov = ov3; c_ol = ol3; c_on = on3; c_idx = {1'b0, oi3}; end
            default: ;
        endcase
    end

    typedef struct {
        int          s;
        logic [7:0]  v;
        int          n;
        logic [31:0] seq;   // expected beat k in seq[4k+3:4k]
        bit          none;
        bit          tog;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    task automatic run_vec(input int s, input logic [7:0] v, input int n,
                           input logic [31:0] seq, input bit none, input bit tog);
        int beats;
        int cyc;
        @(negedge clk);
        sel = s; vin = v; ivld = 1'b1; out_ready = 1'b1;
        chk("in_ready_idle", {31'b0, c_ir}, 1);
        chk("out_valid_idle", {31'b0, c_ov}, 0);
        @(negedge clk);
        ivld = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < n && cyc < 40) begin
            out_ready = tog ? (cyc % 2 == 0) : 1'b1;
            chk("out_valid_scan", {31'b0, c_ov}, 1);
            if (!c_ov) break;
            chk("out_idx", {28'b0, c_idx}, {28'b0, seq[4*beats +: 4]});
            chk("out_last", {31'b0, c_ol}, {31'b0, (beats == n - 1)});
            chk("out_none", {31'b0, c_on}, {31'b0, none});
            if (out_ready) beats++;
            cyc++;
            @(negedge clk);
        end
        chk("beat_count", beats, n);
        chk("in_ready_after", {31'b0, c_ir}, 1);
        chk("out_valid_after", {31'b0, c_ov}, 0);
        chk("idle_idx_zero", {28'b0, c_idx}, 0);
        chk("idle_last_zero", {31'b0, c_ol}, 0);
        chk("idle_none_zero", {31'b0, c_on}, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 8'b1010_0110, 4, 32'h0000_7521, 1'b0, 1'b0};
        tbl[1]  = '{1, 8'b1010_0110, 4, 32'h0000_1257, 1'b0, 1'b1};
        tbl[2]  = '{2, 8'hFF,        1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[3]  = '{2, 8'b1111_0111, 1, 32'h0000_0003, 1'b0, 1'b0};
        tbl[4]  = '{0, 8'h00,        1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[5]  = '{0, 8'h80,        1, 32'h0000_0007, 1'b0, 1'b0};
        tbl[6]  = '{1, 8'h01,        1, 32'h0000_0000, 1'b0, 1'b1};
        tbl[7]  = '{3, 8'b0001_0001, 2, 32'h0000_0040, 1'b0, 1'b0};
        tbl[8]  = '{1, 8'hFF,        8, 32'h0123_4567, 1'b0, 1'b1};
        tbl[9]  = '{2, 8'b0101_1010, 4, 32'h0000_7520, 1'b0, 1'b0};
        tbl[10] = '{0, 8'hFF,        8, 32'h7654_3210, 1'b0, 1'b1};
        tbl[11] = '{3, 8'b0001_1110, 4, 32'h0000_4321, 1'b0, 1'b0};

        // Reset state, observed before any clock edge.
        #2;
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            chk("reset_in_ready", {31'b0, c_ir}, 1);
            chk("reset_out_valid", {31'b0, c_ov}, 0);
            chk("reset_out_idx", {28'b0, c_idx}, 0);
        end
        sel = 0;
        @(posedge clk);
        #2 reset = 1'b0;

        for (int t = 0; t < 12; t++) begin
            run_vec(tbl[t].s, tbl[t].v, tbl[t].n, tbl[t].seq, tbl[t].none, tbl[t].tog);
        end

        // Flush coincident with the first beat of 5'b10001.
        @(negedge clk);
        sel = 3; vin = 8'b0001_0001; ivld = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_first_beat_vld", {31'b0, c_ov}, 1);
        chk("flush_first_beat_idx", {28'b0, c_idx}, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ivld = 1'b0;
        chk("flush_out_valid", {31'b0, c_ov}, 0);
        chk("flush_in_ready", {31'b0, c_ir}, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_no_beats", {31'b0, c_ov}, 0);
        end

        // Flush in IDLE blocks a coincident in_valid.
        flush = 1'b1; ivld = 1'b1; vin = 8'b0000_0100;
        @(negedge clk);
        flush = 1'b0; ivld = 1'b0;
        chk("flush_blocks_accept", {31'b0, c_ov}, 0);
        run_vec(3, 8'b0000_0100, 1, 32'h2, 1'b0, 1'b0);

        // Asynchronous reset mid-scan of 8'hFF.
        @(negedge clk);
        sel = 0; vin = 8'hFF; ivld = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        ivld = 1'b0;
        chk("pre_reset_idx0", {28'b0, c_idx}, 0);
        @(negedge clk);
        chk("pre_reset_idx1", {28'b0, c_idx}, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out_valid", {31'b0, c_ov}, 0);
        chk("async_reset_in_ready", {31'b0, c_ir}, 1);
        chk("async_reset_idx", {28'b0, c_idx}, 0);
        chk("async_reset_last", {31'b0, c_ol}, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_no_beats", {31'b0, c_ov}, 0);
        end
        run_vec(0, 8'b0100_1000, 2, 32'h63, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
